// File: rtl/tank_move_ctrl.sv
// tank_move_ctrl: commits the tank sprite position once per frame, at the start of vertical blank.
// The position comes from local buttons or from a remote link. Define TANK_WRAP_EN to make local moves wrap.
module tank_move_ctrl #(
    parameter logic [11:0] X_INIT    = 12'd100,
    parameter logic [11:0] Y_INIT    = 12'd400,
    parameter logic [11:0] X_LIM     = 12'd736,
    parameter logic [11:0] Y_LIM     = 12'd536,
    parameter logic [11:0] STEP      = 12'd4,
    parameter logic [3:0]  FRAME_DIV = 4'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        SelectMode,
    input  logic        mv_up,
    input  logic        mv_down,
    input  logic        mv_left,
    input  logic        mv_right,
    input  logic        remote_valid,
    input  logic [9:0]  remote_x,
    input  logic [9:0]  remote_y,
    output logic        remote_ack,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        pos_upd,
    output logic        at_edge
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        MOVE   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        vblnk_d_r;
    logic        vblnk_rise_s;
    logic        sample_en_s;
    logic        move_en_s;
    logic        commit_en_s;
    logic [3:0]  div_r;
    logic [3:0]  div_inc_s;
    logic        sel_r;
    logic        up_r;
    logic        down_r;
    logic        left_r;
    logic        right_r;
    logic        full_lat_r;
    logic        full_r;
    logic [11:0] hold_x_r;
    logic [11:0] hold_y_r;
    logic        ack_r;
    logic        capture_s;
    logic [12:0] step_x_s;
    logic [12:0] step_y_s;
    logic [12:0] rem_x_s;
    logic [12:0] rem_y_s;
    logic [11:0] calc_x_s;
    logic [11:0] calc_y_s;
    logic        calc_edge_s;
    logic [11:0] next_x_r;
    logic [11:0] next_y_r;
    logic        next_edge_r;
    logic [11:0] xpos_r;
    logic [11:0] ypos_r;
    logic        upd_r;
    logic        edge_r;

    // Local move on one axis. The result is {limit_hit, new_pos}. The sum is 13 bits wide to catch overflow.
    function automatic logic [12:0] local_step(input logic [11:0] pos, input logic [11:0] lim,
                                               input logic inc, input logic dec);
        logic [12:0] sum_v;
        logic [12:0] res_v;
        sum_v = {1'b0, pos} + {1'b0, STEP};
        res_v = {1'b0, pos};
        if (inc && !dec) begin
            if (sum_v > {1'b0, lim}) begin
`ifdef TANK_WRAP_EN
                res_v = {1'b1, sum_v[11:0] - lim - 12'd1};
`else
                res_v = {1'b1, lim};
`endif
            end else begin
                res_v = {1'b0, sum_v[11:0]};
            end
        end else if (dec && !inc) begin
            if (pos < STEP) begin
`ifdef TANK_WRAP_EN
                res_v = {1'b1, lim - (STEP - pos - 12'd1)};
`else
                res_v = {1'b1, 12'd0};
`endif
            end else begin
                res_v = {1'b0, pos - STEP};
            end
        end else begin
            res_v = {1'b0, pos};
        end
        return res_v;
    endfunction

    // Remote positions are always clamped, even in wrap builds
    function automatic logic [12:0] remote_clamp(input logic [11:0] val, input logic [11:0] lim);
        logic [12:0] res_v;
        if (val > lim) begin
            res_v = {1'b1, lim};
        end else begin
            res_v = {1'b0, val};
        end
        return res_v;
    endfunction

    assign vblnk_rise_s = vblnk & ~vblnk_d_r;
    assign capture_s    = remote_valid & ~full_r;
    assign div_inc_s    = (div_r >= (FRAME_DIV - 4'd1)) ? 4'd0 : (div_r + 4'd1);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (vblnk_rise_s) begin
                    state_nxt_s = SAMPLE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SAMPLE:  state_nxt_s = MOVE;
            MOVE:    state_nxt_s = COMMIT;
            COMMIT:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM phase strobes
    always_comb begin
        sample_en_s = 1'b0;
        move_en_s   = 1'b0;
        commit_en_s = 1'b0;
        case (state_r)
            SAMPLE:  sample_en_s = 1'b1;
            MOVE:    move_en_s   = 1'b1;
            COMMIT:  commit_en_s = 1'b1;
            default: sample_en_s = 1'b0;
        endcase
    end

    // The vblnk history resets high, so a blank already in progress at reset release is not seen as an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vblnk_d_r <= 1'b1;
        end else begin
            vblnk_d_r <= vblnk;
        end
    end

    // Snapshot of the mode, the buttons and the holding status, plus the frame divider step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_r      <= 4'd0;
            sel_r      <= 1'b0;
            up_r       <= 1'b0;
            down_r     <= 1'b0;
            left_r     <= 1'b0;
            right_r    <= 1'b0;
            full_lat_r <= 1'b0;
        end else if (sample_en_s) begin
            div_r      <= div_inc_s;
            sel_r      <= SelectMode;
            up_r       <= mv_up;
            down_r     <= mv_down;
            left_r     <= mv_left;
            right_r    <= mv_right;
            full_lat_r <= full_r;
        end
    end

    // Single-entry remote holding register. A capture takes priority over the clear at commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_r   <= 1'b0;
            hold_x_r <= 12'd0;
            hold_y_r <= 12'd0;
            ack_r    <= 1'b0;
        end else begin
            ack_r <= capture_s;
            if (capture_s) begin
                full_r   <= 1'b1;
                hold_x_r <= {2'b00, remote_x};
                hold_y_r <= {2'b00, remote_y};
            end else if (commit_en_s && sel_r && full_lat_r) begin
                full_r <= 1'b0;
            end
        end
    end

    // Candidate position for this frame
    always_comb begin
        step_x_s    = local_step(xpos_r, X_LIM, right_r, left_r);
        step_y_s    = local_step(ypos_r, Y_LIM, down_r, up_r);
        rem_x_s     = remote_clamp(hold_x_r, X_LIM);
        rem_y_s     = remote_clamp(hold_y_r, Y_LIM);
        calc_x_s    = xpos_r;
        calc_y_s    = ypos_r;
        calc_edge_s = 1'b0;
        if (sel_r) begin
            if (full_lat_r) begin
                calc_x_s    = rem_x_s[11:0];
                calc_y_s    = rem_y_s[11:0];
                calc_edge_s = rem_x_s[12] | rem_y_s[12];
            end else begin
                calc_edge_s = 1'b0;
            end
        end else if (div_r == 4'd0) begin
            calc_x_s    = step_x_s[11:0];
            calc_y_s    = step_y_s[11:0];
            calc_edge_s = step_x_s[12] | step_y_s[12];
        end else begin
            calc_edge_s = 1'b0;
        end
    end

    // Hold the computed position until the commit phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            next_x_r    <= X_INIT;
            next_y_r    <= Y_INIT;
            next_edge_r <= 1'b0;
        end else if (move_en_s) begin
            next_x_r    <= calc_x_s;
            next_y_r    <= calc_y_s;
            next_edge_r <= calc_edge_s;
        end
    end

    // Committed outputs. pos_upd pulses on every commit, even when the position does not change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xpos_r <= X_INIT;
            ypos_r <= Y_INIT;
            upd_r  <= 1'b0;
            edge_r <= 1'b0;
        end else begin
            upd_r <= commit_en_s;
            if (commit_en_s) begin
                xpos_r <= next_x_r;
                ypos_r <= next_y_r;
                edge_r <= next_edge_r;
            end
        end
    end

    assign remote_ack = ack_r;
    assign xpos       = xpos_r;
    assign ypos       = ypos_r;
    assign pos_upd    = upd_r;
    assign at_edge    = edge_r;

endmodule
